// File: rtl/spi_level_tx_if.sv
// -----------------------------------------------------------------------------
// spi_level_tx_if
// Valid/ready word handshake between a level-word source and spi_level_tx.
//   tx_data  : word to send, sampled by the sink only on the accept edge
//   tx_valid : source holds a word (must stay high until accepted)
//   tx_ready : sink can take a word this cycle (registered in the sink)
// Modports: master = word source, slave = spi_level_tx.
// -----------------------------------------------------------------------------
interface spi_level_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/spi_level_tx.sv
// -----------------------------------------------------------------------------
// spi_level_tx
// SPI mode-0 master sending one DATA_W-bit level word per frame, MSB first,
// to the downstream SPI-slave PWM/LED stage. sclk is derived by dividing clk;
// cs_n setup/hold/idle times are sized for the slave's 3-flop cs_n synchroniser.
// Ports:
//   i_clk        : system clock (single domain)
//   i_rst        : synchronous active-high reset
//   io           : word handshake (tx_data / tx_valid / tx_ready), slave side
//   o_busy       : frame or inter-frame gap in progress
//   o_frame_done : one-cycle pulse on the cycle cs_n returns high
//   o_cs_n       : SPI chip select, active low
//   o_sclk       : SPI clock, idles low
//   o_sdi        : SPI data, MSB first
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_level_tx #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  spi_level_tx_if.slave    io,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_cs_n,
  output logic             o_sclk,
  output logic             o_sdi
);

  // One shared phase counter serves SETUP, SHIFT half-periods, HOLD and GAP,
  // so it is sized for the largest of those terminal counts.
  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  // tx_ready is registered, so it is raised one cycle before the gap ends;
  // the earliest accept edge then lands exactly CS_IDLE cycles after cs_n rose.
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_IDLE - 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Parameter legality, rejected at elaboration.
  generate
    if (DATA_W < 1) begin : g_chk_data_w
      $error("spi_level_tx: DATA_W must be >= 1");
    end
    if (CLK_DIV < 1) begin : g_chk_clk_div
      $error("spi_level_tx: CLK_DIV must be >= 1");
    end
    if (CS_SETUP < 1) begin : g_chk_cs_setup
      $error("spi_level_tx: CS_SETUP must be >= 1");
    end
    if (CS_HOLD < 1) begin : g_chk_cs_hold
      $error("spi_level_tx: CS_HOLD must be >= 1");
    end
    if (CS_IDLE < 3) begin : g_chk_cs_idle
      $error("spi_level_tx: CS_IDLE must be >= 3");
    end
  endgenerate

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_cs_n;
  logic              r_sclk;
  logic              r_sdi;
  logic              r_tx_ready;
  logic              r_busy;
  logic              r_frame_done;

  logic              w_accept;
  logic [DATA_W-1:0] w_shift_next;

  assign w_accept     = io.tx_valid & r_tx_ready;
  assign w_shift_next = r_shift << 1;

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_cs_n       <= 1'b1;
      r_sclk       <= 1'b0;
      r_sdi        <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift    <= io.tx_data;
            r_sdi      <= io.tx_data[DATA_W-1];
            r_cs_n     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_state    <= ST_SETUP;
          end else begin
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end

        ST_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_sclk  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            // Data only moves on falling sclk so it is stable across each rise.
            if (r_sclk) begin
              if (r_bit == BIT_LAST) begin
                r_state <= ST_HOLD;
              end else begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= w_shift_next;
                r_sdi   <= w_shift_next[DATA_W-1];
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cs_n       <= 1'b1;
            r_sdi        <= 1'b0;
            r_frame_done <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_bit      <= '0;
          r_cs_n     <= 1'b1;
          r_sclk     <= 1'b0;
          r_sdi      <= 1'b0;
          r_tx_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign io.tx_ready  = r_tx_ready;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_cs_n       = r_cs_n;
  assign o_sclk       = r_sclk;
  assign o_sdi        = r_sdi;

endmodule

// File: tb/tb_spi_level_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_level_tx
// Directed bench for spi_level_tx. dut_a uses default timing, dut_b uses
// CLK_DIV=1 / CS_SETUP=1 / CS_HOLD=1. Each DUT drives a model of the
// downstream slave (sdi shifted on sclk rise while cs_n low, word latched
// after a 3-flop cs_n synchroniser sees the rising edge).
// -----------------------------------------------------------------------------
module tb_spi_level_tx;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_level_tx_if #(.DATA_W(16)) a_if ();
  spi_level_tx_if #(.DATA_W(16)) b_if ();

  logic a_busy, a_fd, a_cs_n, a_sclk, a_sdi;
  logic b_busy, b_fd, b_cs_n, b_sclk, b_sdi;

  spi_level_tx #(.DATA_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .io(a_if),
    .o_busy(a_busy), .o_frame_done(a_fd), .o_cs_n(a_cs_n),
    .o_sclk(a_sclk), .o_sdi(a_sdi)
  );

  spi_level_tx #(.DATA_W(16), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .io(b_if),
    .o_busy(b_busy), .o_frame_done(b_fd), .o_cs_n(b_cs_n),
    .o_sclk(b_sclk), .o_sdi(b_sdi)
  );

  // Downstream slave models
  logic [15:0] a_sh = 16'h0000, a_level = 16'h0000;
  logic [15:0] b_sh = 16'h0000, b_level = 16'h0000;
  logic [2:0]  a_sync = 3'b111, b_sync = 3'b111;

  always @(posedge a_sclk) if (!a_cs_n) a_sh <= {a_sh[14:0], a_sdi};
  always @(posedge b_sclk) if (!b_cs_n) b_sh <= {b_sh[14:0], b_sdi};

  always @(posedge clk) begin
    a_sync <= {a_sync[1:0], a_cs_n};
    if (a_sync[1] && !a_sync[2]) a_level <= a_sh;
    b_sync <= {b_sync[1:0], b_cs_n};
    if (b_sync[1] && !b_sync[2]) b_level <= b_sh;
  end

  typedef struct {
    logic [15:0] word;
    bit          sel;
    int          setup;
    int          div;
    int          exp_low;
    int          exp_ready;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {cs_n, sclk, sdi, tx_ready, busy, frame_done}
  function automatic logic [5:0] outs(input bit sel);
    if (sel) return {b_cs_n, b_sclk, b_sdi, b_if.tx_ready, b_busy, b_fd};
    else     return {a_cs_n, a_sclk, a_sdi, a_if.tx_ready, a_busy, a_fd};
  endfunction

  function automatic logic [15:0] level(input bit sel);
    return sel ? b_level : a_level;
  endfunction

  task automatic set_valid(input bit sel, input logic v);
    if (sel) b_if.tx_valid = v;
    else     a_if.tx_valid = v;
  endtask

  task automatic set_data(input bit sel, input logic [15:0] d);
    if (sel) b_if.tx_data = d;
    else     a_if.tx_data = d;
  endtask

  // Returns on a negedge where tx_ready is high (bounded).
  task automatic wait_ready(input bit sel);
    int t;
    logic [5:0] o;
    t = 0;
    @(negedge clk);
    o = outs(sel);
    while (!o[2] && t < 400) begin
      @(negedge clk);
      o = outs(sel);
      t++;
    end
    if (!o[2]) chk("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  // Follows one frame from its accept edge (n=0) to the edge tx_ready returns.
  task automatic monitor(input string nm, input bit sel, input logic [15:0] word,
                         input int setup, input int div, input int exp_low,
                         input int exp_ready, input bit keep,
                         input int poke1, input int poke2, output int e0);
    logic [5:0]  o;
    logic [15:0] cap;
    logic        prev_sclk;
    int rises, bad_t, low, rise_n, fd_cnt, fd_n, rdy_n, sclk_hi;
    cap = 16'h0000; prev_sclk = 1'b0;
    rises = 0; bad_t = 0; low = 0; rise_n = -1; fd_cnt = 0; fd_n = -1; rdy_n = -1; sclk_hi = 0;
    @(posedge clk); #1;
    e0 = cyc;
    o = outs(sel);
    chk({nm, "_accept_outs"}, {26'd0, o}, {26'd0, 1'b0, 1'b0, word[15], 1'b0, 1'b1, 1'b0});
    if (!keep) set_valid(sel, 1'b0);
    if (!o[5]) low++;
    for (int n = 1; n <= exp_ready; n++) begin
      @(posedge clk); #1;
      o = outs(sel);
      if (o[4] && !prev_sclk) begin
        if (n != setup + 2 * rises * div) bad_t++;
        cap = {cap[14:0], o[3]};
        rises++;
      end
      prev_sclk = o[4];
      if (!o[5]) low++;
      else if (rise_n < 0) rise_n = n;
      if (o[5] && o[4]) sclk_hi++;
      if (o[0]) begin fd_cnt++; fd_n = n; end
      if (o[2] && rdy_n < 0) rdy_n = n;
      if (n == poke1 || n == poke2) begin
        set_data(sel, 16'h1234);
        set_valid(sel, 1'b1);
      end else if (n == poke1 + 1 || n == poke2 + 1) begin
        set_valid(sel, 1'b0);
      end
    end
    chk({nm, "_rise_count"}, rises, 16);
    chk({nm, "_rise_timing_errs"}, bad_t, 0);
    chk({nm, "_sdi_word"}, {16'd0, cap}, {16'd0, word});
    chk({nm, "_cs_low_cycles"}, low, exp_low);
    chk({nm, "_cs_rise_edge"}, rise_n, exp_low);
    chk({nm, "_frame_done_count"}, fd_cnt, 1);
    chk({nm, "_frame_done_edge"}, fd_n, exp_low);
    chk({nm, "_ready_edge"}, rdy_n, exp_ready);
    chk({nm, "_sclk_while_cs_high"}, sclk_hi, 0);
    chk({nm, "_busy_end"}, {31'd0, o[1]}, 32'd0);
    chk({nm, "_slave_level"}, {16'd0, level(sel)}, {16'd0, word});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0a, e0b, extra;

    vecs[0] = '{16'hA5C3, 1'b0, 2, 4, 128, 131};
    vecs[1] = '{16'h8000, 1'b1, 1, 1, 33, 36};
    vecs[2] = '{16'h7E18, 1'b0, 2, 4, 128, 131};
    vecs[3] = '{16'hFFFE, 1'b1, 1, 1, 33, 36};

    // Reset with a pending word: outputs pinned, no sclk activity
    rst = 1'b1;
    set_data(1'b0, 16'hDEAD); set_valid(1'b0, 1'b1);
    set_data(1'b1, 16'hDEAD); set_valid(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("reset_outs_a", {26'd0, outs(1'b0)}, {26'd0, 6'b100000});
      chk("reset_outs_b", {26'd0, outs(1'b1)}, {26'd0, 6'b100000});
    end
    rst = 1'b0;
    set_valid(1'b0, 1'b0);
    set_valid(1'b1, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_reset_a", {26'd0, outs(1'b0)}, {26'd0, 6'b100100});
    chk("ready_after_reset_b", {26'd0, outs(1'b1)}, {26'd0, 6'b100100});

    // Single frames from the table
    for (int i = 0; i < 4; i++) begin
      wait_ready(vecs[i].sel);
      set_data(vecs[i].sel, vecs[i].word);
      set_valid(vecs[i].sel, 1'b1);
      monitor($sformatf("vec%0d", i), vecs[i].sel, vecs[i].word, vecs[i].setup,
              vecs[i].div, vecs[i].exp_low, vecs[i].exp_ready, 1'b0, -1, -1, e0a);
    end

    // Back-to-back with tx_valid held high
    wait_ready(1'b0);
    set_data(1'b0, 16'h0001);
    set_valid(1'b0, 1'b1);
    monitor("b2b_first", 1'b0, 16'h0001, 2, 4, 128, 131, 1'b1, -1, -1, e0a);
    set_data(1'b0, 16'hFFFF);
    monitor("b2b_second", 1'b0, 16'hFFFF, 2, 4, 128, 131, 1'b0, -1, -1, e0b);
    chk("b2b_period", e0b - e0a, 132);

    // tx_valid pulses while busy are ignored
    wait_ready(1'b0);
    set_data(1'b0, 16'h00FF);
    set_valid(1'b0, 1'b1);
    monitor("busy_ignore", 1'b0, 16'h00FF, 2, 4, 128, 131, 1'b0, 20, 129, e0a);
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!a_cs_n || a_sclk) extra++;
    end
    chk("busy_ignore_no_extra_frame", extra, 0);
    chk("busy_ignore_level_kept", {16'd0, a_level}, {16'd0, 16'h00FF});

    // Reset mid-frame, then a clean frame
    wait_ready(1'b0);
    set_data(1'b0, 16'hC3C3);
    set_valid(1'b0, 1'b1);
    @(posedge clk); #1;
    set_valid(1'b0, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_frame_reset_outs", {26'd0, outs(1'b0)}, {26'd0, 6'b100000});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_frame_reset_release", {26'd0, outs(1'b0)}, {26'd0, 6'b100100});
    wait_ready(1'b0);
    set_data(1'b0, 16'h5A5A);
    set_valid(1'b0, 1'b1);
    monitor("after_reset", 1'b0, 16'h5A5A, 2, 4, 128, 131, 1'b0, -1, -1, e0a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
